dm_responder: RTL and testbench

- Memory-side responder for the pipeline's data-memory port, replacing the single-cycle dm with a wait-stated, handshaked slave.
- Accepts one load/store request at a time from the MEM stage.
- Holds word storage internally and inserts a configurable number of wait states.
- Returns a one-cycle response pulse with read data and an error flag. Its busy output feeds hazard_ctrl as a stall source.

---
 rtl/dm_resp_pkg.sv | 20 ++
 rtl/dm_resp_array.sv | 26 ++
 rtl/dm_responder.sv | 116 +++++++++++
 tb/tb_dm_responder.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_resp_pkg.sv
// Shared types and helpers for the wait-stated data-memory responder.
// Holds the FSM state encoding, the wait counter width and the access fault check.
package dm_resp_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAITS = 2'd1,
        RESP  = 2'd2
    } state_t;

    // A fault is a misaligned word access or any address bit above the array.
    function automatic logic isFault(input logic [31:0] addr, input int depthLog2);
        logic [31:0] highMask;
        highMask = 32'hFFFF_FFFF << (depthLog2 + 2);
        return (addr[1:0] != 2'b00) || ((addr & highMask) != 32'h0);
    endfunction

endpackage

// File: rtl/dm_resp_array.sv
// Word storage behind the responder: one synchronous write port and one
// combinational read port. Contents are deliberately left untouched by reset.
module dm_resp_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clock,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [31:0]           i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [31:0]           o_rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dm_responder.sv
// Handshaked data-memory slave for the MEM stage: accepts one request at a time,
// inserts WAIT wait states, then returns a one-cycle rvalid pulse with data and err.
module dm_responder
    import dm_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT       = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] data_out,
    output logic        err,
    output logic        busy
);

    if (WAIT < 0 || WAIT > (1 << CNT_W) - 1) begin : g_waitRangeCheck
        $fatal(1, "dm_responder: WAIT must lie in 0..15 (4-bit wait counter)");
    end

    localparam bit               ZERO_WAIT = (WAIT == 0);
    localparam logic [CNT_W-1:0] CNT_INIT  = ZERO_WAIT ? '0 : CNT_W'(WAIT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_data;
    logic [31:0]      r_dataOut;
    logic             r_err;

    logic             w_accept;
    logic             w_access;
    logic             w_accWe;
    logic [31:0]      w_accAddr;
    logic [31:0]      w_accData;
    logic             w_fault;
    logic             w_memWe;
    logic [31:0]      w_rdata;

    // With no wait states the access happens on the accept edge itself, so the
    // live request fields are used instead of the latched copies.
    assign w_accept  = req && (r_state != WAITS);
    assign w_access  = ZERO_WAIT ? w_accept : ((r_state == WAITS) && (r_cnt == '0));
    assign w_accWe   = ZERO_WAIT ? we      : r_we;
    assign w_accAddr = ZERO_WAIT ? address : r_addr;
    assign w_accData = ZERO_WAIT ? data_in : r_data;
    assign w_fault   = isFault(w_accAddr, DEPTH_LOG2);
    assign w_memWe   = w_access && w_accWe && !w_fault;

    dm_resp_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clock   (clock),
        .i_we    (w_memWe),
        .i_waddr (w_accAddr[DEPTH_LOG2+1:2]),
        .i_wdata (w_accData),
        .i_raddr (w_accAddr[DEPTH_LOG2+1:2]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_dataOut <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we   <= we;
                r_addr <= address;
                r_data <= data_in;
            end

            case (r_state)
                IDLE, RESP: begin
                    if (req) begin
                        r_state <= ZERO_WAIT ? RESP : WAITS;
                        r_cnt   <= CNT_INIT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WAITS: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Response registers only move on access edges and hold otherwise.
            if (w_access) begin
                r_dataOut <= (w_fault || w_accWe) ? 32'h0 : w_rdata;
                r_err     <= w_fault;
            end
        end
    end

    assign ready    = (r_state != WAITS);
    assign busy     = (r_state == WAITS);
    assign rvalid   = (r_state == RESP);
    assign data_out = r_dataOut;
    assign err      = r_err;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: three instances (WAIT=2, 3, 0) share the
// request fields; a scoreboard queue holds expected responses pushed at issue time.
module tb_dm_responder;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] dataIn = 32'h0;
    int          dutSel = 0;

    logic        req2, req3, req0;
    logic        ready2, rvalid2, err2, busy2;
    logic        ready3, rvalid3, err3, busy3;
    logic        ready0, rvalid0, err0, busy0;
    logic [31:0] dataOut2, dataOut3, dataOut0;

    logic        obsReady, obsRvalid, obsErr, obsBusy;
    logic [31:0] obsDataOut;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    assign req2 = req && (dutSel == 0);
    assign req3 = req && (dutSel == 1);
    assign req0 = req && (dutSel == 2);

    dm_responder #(.DEPTH_LOG2(10), .WAIT(2)) u_dutW2 (
        .clock(clock), .reset(reset), .req(req2), .we(we), .address(address),
        .data_in(dataIn), .ready(ready2), .rvalid(rvalid2), .data_out(dataOut2),
        .err(err2), .busy(busy2)
    );

    dm_responder #(.DEPTH_LOG2(10), .WAIT(3)) u_dutW3 (
        .clock(clock), .reset(reset), .req(req3), .we(we), .address(address),
        .data_in(dataIn), .ready(ready3), .rvalid(rvalid3), .data_out(dataOut3),
        .err(err3), .busy(busy3)
    );

    dm_responder #(.DEPTH_LOG2(10), .WAIT(0)) u_dutW0 (
        .clock(clock), .reset(reset), .req(req0), .we(we), .address(address),
        .data_in(dataIn), .ready(ready0), .rvalid(rvalid0), .data_out(dataOut0),
        .err(err0), .busy(busy0)
    );

    always_comb begin
        obsReady = ready2; obsRvalid = rvalid2; obsErr = err2; obsBusy = busy2; obsDataOut = dataOut2;
        if (dutSel == 1) begin
            obsReady = ready3; obsRvalid = rvalid3; obsErr = err3; obsBusy = busy3; obsDataOut = dataOut3;
        end else if (dutSel == 2) begin
            obsReady = ready0; obsRvalid = rvalid0; obsErr = err0; obsBusy = busy0; obsDataOut = dataOut0;
        end
    end

    // Issues one request from an idle/RESP cycle and waits (bounded) for rvalid.
    task automatic runAccess(input logic w, input logic [31:0] a, input logic [31:0] d,
                             output bit seen, output int lat, output int busyCnt,
                             output logic [31:0] rd, output logic re);
        we = w; address = a; dataIn = d; req = 1'b1;
        seen = 1'b0; lat = 0; busyCnt = 0; rd = 32'h0; re = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clock); #1;
            req = 1'b0;
            lat++;
            if (obsBusy) busyCnt++;
            if (obsRvalid) begin
                seen = 1'b1; rd = obsDataOut; re = obsErr;
            end
        end
    endtask

    task automatic test_reset_initial();
        dutSel = 0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({obsReady, obsRvalid, obsBusy, obsErr} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got ready/rvalid/busy/err=%b expected 1000",
                     {obsReady, obsRvalid, obsBusy, obsErr});
        end
        checks++;
        if (obsDataOut !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 00000000", obsDataOut);
        end
    endtask

    task automatic test_store_load();
        logic        tWe   [2];
        logic [31:0] tAddr [2];
        logic [31:0] tData [2];
        logic [31:0] tExp  [2];
        bit seen; int lat, busyCnt; logic [31:0] rd; logic re; exp_t e;
        tWe = '{1'b1, 1'b0};
        tAddr = '{32'h10, 32'h10};
        tData = '{32'hDEADBEEF, 32'h0};
        tExp = '{32'h0, 32'hDEADBEEF};
        dutSel = 0;
        for (int i = 0; i < 2; i++) begin
            expQ.push_back('{tExp[i], 1'b0});
            runAccess(tWe[i], tAddr[i], tData[i], seen, lat, busyCnt, rd, re);
            e = expQ.pop_front();
            checks++;
            if (!seen || {rd, re} !== {e.data, e.err}) begin
                errors++;
                $display("[TB] FAIL sl_resp[%0d]: got seen=%0b data=%h err=%b expected data=%h err=%b",
                         i, seen, rd, re, e.data, e.err);
            end
            checks++;
            if (lat != 3 || busyCnt != 2) begin
                errors++;
                $display("[TB] FAIL sl_timing[%0d]: got lat=%0d busy=%0d expected lat=3 busy=2", i, lat, busyCnt);
            end
            @(posedge clock); #1;
            checks++;
            if (obsRvalid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL sl_pulse[%0d]: got rvalid=%b expected 0 after one cycle", i, obsRvalid);
            end
        end
    endtask

    task automatic test_faults();
        logic        tWe   [7];
        logic [31:0] tAddr [7];
        logic [31:0] tData [7];
        logic [31:0] tExp  [7];
        logic        tErr  [7];
        bit seen; int lat, busyCnt; logic [31:0] rd; logic re; exp_t e;
        tWe   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tAddr = '{32'h13, 32'h20, 32'h22, 32'h20, 32'h1000, 32'hFFC, 32'hFFC};
        tData = '{32'h0, 32'hA5A5A5A5, 32'h12345678, 32'h0, 32'h0, 32'h0BADF00D, 32'h0};
        tExp  = '{32'h0, 32'h0, 32'h0, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0BADF00D};
        tErr  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        dutSel = 0;
        for (int i = 0; i < 7; i++) begin
            expQ.push_back('{tExp[i], tErr[i]});
            runAccess(tWe[i], tAddr[i], tData[i], seen, lat, busyCnt, rd, re);
            e = expQ.pop_front();
            checks++;
            if (!seen || {rd, re} !== {e.data, e.err}) begin
                errors++;
                $display("[TB] FAIL fault_resp[%0d] addr=%h: got seen=%0b data=%h err=%b expected data=%h err=%b",
                         i, tAddr[i], seen, rd, re, e.data, e.err);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        int respTime [3];
        int idx, nResp;
        bit accNow, seen; int lat, busyCnt; logic [31:0] rd; logic re; exp_t e;
        vals = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008};
        dutSel = 0;
        for (int i = 0; i < 3; i++) begin
            expQ.push_back('{32'h0, 1'b0});
            runAccess(1'b1, 32'(i * 4), vals[i], seen, lat, busyCnt, rd, re);
            e = expQ.pop_front();
            checks++;
            if (!seen || {rd, re} !== {e.data, e.err}) begin
                errors++;
                $display("[TB] FAIL b2b_preset[%0d]: got seen=%0b data=%h err=%b", i, seen, rd, re);
            end
        end
        idx = 0; nResp = 0;
        respTime = '{0, 0, 0};
        we = 1'b0; address = 32'h0; req = 1'b1;
        expQ.push_back('{vals[0], 1'b0});
        for (int cyc = 1; cyc <= 40 && nResp < 3; cyc++) begin
            accNow = req && obsReady;
            @(posedge clock); #1;
            if (accNow) begin
                idx++;
                if (idx < 3) begin
                    address = 32'(idx * 4);
                    expQ.push_back('{vals[idx], 1'b0});
                end else begin
                    req = 1'b0;
                end
            end
            if (obsRvalid) begin
                e = expQ.pop_front();
                checks++;
                if ({obsDataOut, obsErr} !== {e.data, e.err}) begin
                    errors++;
                    $display("[TB] FAIL b2b_data[%0d]: got data=%h err=%b expected data=%h err=%b",
                             nResp, obsDataOut, obsErr, e.data, e.err);
                end
                respTime[nResp] = cyc;
                nResp++;
            end
        end
        req = 1'b0;
        checks++;
        if (nResp != 3) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d responses expected 3", nResp);
        end
        checks++;
        if (respTime[1] - respTime[0] != 3 || respTime[2] - respTime[1] != 3) begin
            errors++;
            $display("[TB] FAIL b2b_spacing: got gaps %0d,%0d expected 3,3",
                     respTime[1] - respTime[0], respTime[2] - respTime[1]);
        end
        expQ.delete();
    endtask

    task automatic test_reset_midrun();
        bit seen, sawRvalid; int lat, busyCnt; logic [31:0] rd; logic re; exp_t e;
        dutSel = 0;
        expQ.push_back('{32'hDEADBEEF, 1'b0});
        runAccess(1'b0, 32'h10, 32'h0, seen, lat, busyCnt, rd, re);
        e = expQ.pop_front();
        checks++;
        if (!seen || {rd, re} !== {e.data, e.err}) begin
            errors++;
            $display("[TB] FAIL rst_pre: got seen=%0b data=%h err=%b expected data=%h", seen, rd, re, e.data);
        end
        we = 1'b0; address = 32'h20; req = 1'b1;
        @(posedge clock); #1;
        req = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({obsReady, obsRvalid, obsBusy, obsErr} !== 4'b1000 || obsDataOut !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_midrun: got ready/rvalid/busy/err=%b data=%h expected 1000 00000000",
                     {obsReady, obsRvalid, obsBusy, obsErr}, obsDataOut);
        end
        sawRvalid = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
            if (obsRvalid) sawRvalid = 1'b1;
        end
        checks++;
        if (sawRvalid) begin
            errors++;
            $display("[TB] FAIL rst_no_resp: got rvalid=1 after reset expected none");
        end
    endtask

    task automatic test_reset_store();
        bit seen, sawRvalid, readyLow; int lat, busyCnt; logic [31:0] rd; logic re; exp_t e;
        dutSel = 1;
        expQ.push_back('{32'h0, 1'b0});
        runAccess(1'b1, 32'h40, 32'h11111111, seen, lat, busyCnt, rd, re);
        e = expQ.pop_front();
        checks++;
        if (!seen || {rd, re} !== {e.data, e.err} || lat != 4) begin
            errors++;
            $display("[TB] FAIL rs_preset: got seen=%0b data=%h err=%b lat=%0d expected lat=4", seen, rd, re, lat);
        end
        we = 1'b1; address = 32'h40; dataIn = 32'hCAFEF00D; req = 1'b1;
        @(posedge clock); #1;
        req = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({obsReady, obsRvalid, obsBusy} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL rs_async: got ready/rvalid/busy=%b expected 100", {obsReady, obsRvalid, obsBusy});
        end
        sawRvalid = 1'b0; readyLow = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            if (obsRvalid) sawRvalid = 1'b1;
            if (!obsReady) readyLow = 1'b1;
        end
        reset = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
            if (obsRvalid) sawRvalid = 1'b1;
        end
        checks++;
        if (sawRvalid || readyLow) begin
            errors++;
            $display("[TB] FAIL rs_quiet: got rvalid_seen=%0b ready_low=%0b expected 0 0", sawRvalid, readyLow);
        end
        expQ.push_back('{32'h11111111, 1'b0});
        runAccess(1'b0, 32'h40, 32'h0, seen, lat, busyCnt, rd, re);
        e = expQ.pop_front();
        checks++;
        if (!seen || {rd, re} !== {e.data, e.err}) begin
            errors++;
            $display("[TB] FAIL rs_load: got seen=%0b data=%h err=%b expected data=%h", seen, rd, re, e.data);
        end
    endtask

    task automatic test_wait0();
        logic        tWe   [2];
        logic [31:0] tExp  [2];
        bit seen; int lat, busyCnt; logic [31:0] rd; logic re; exp_t e;
        tWe = '{1'b1, 1'b0};
        tExp = '{32'h0, 32'h00000055};
        dutSel = 2;
        for (int i = 0; i < 2; i++) begin
            expQ.push_back('{tExp[i], 1'b0});
            runAccess(tWe[i], 32'h8, 32'h00000055, seen, lat, busyCnt, rd, re);
            e = expQ.pop_front();
            checks++;
            if (!seen || {rd, re} !== {e.data, e.err}) begin
                errors++;
                $display("[TB] FAIL w0_resp[%0d]: got seen=%0b data=%h err=%b expected data=%h", i, seen, rd, re, e.data);
            end
            checks++;
            if (lat != 1 || busyCnt != 0) begin
                errors++;
                $display("[TB] FAIL w0_timing[%0d]: got lat=%0d busy=%0d expected lat=1 busy=0", i, lat, busyCnt);
            end
        end
    endtask

    initial begin
        $display("[TB] dm_responder bench start");
        test_reset_initial();
        test_store_load();
        test_faults();
        test_back_to_back();
        test_reset_midrun();
        test_reset_store();
        test_wait0();
        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
